// File: rtl/crc_tx_framer_if.sv
// Payload-in / framed-out stream bundle for crc_tx_framer.
// The master modport is the framer's view; slave is the surrounding environment.
interface crc_tx_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_crc;
    logic                  m_ready;

    modport master (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last, m_crc
    );

    modport slave (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last, m_crc
    );
endinterface

// File: rtl/crc_tx_framer.sv
// Stream framer: passes payload through a one-deep output register and appends
// the CRC of each frame as an extra beat, driving a bit-serial-equivalent CRC core.

module crc #(
    parameter int DATA_WIDTH = 8,
    parameter int CRC_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  data_in_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CRC_WIDTH-1:0]  init,
    input  logic [CRC_WIDTH:0]    poly,
    input  logic                  data_reverse,
    input  logic                  crc_reverse,
    input  logic [CRC_WIDTH-1:0]  xorout,
    output logic [CRC_WIDTH-1:0]  crc_out
);
    logic [CRC_WIDTH-1:0]  state_q;
    logic [CRC_WIDTH-1:0]  state_d;
    logic [CRC_WIDTH-1:0]  seed;
    logic [CRC_WIDTH-1:0]  stateView;
    logic [DATA_WIDTH-1:0] dataOrdered;
    logic                  fresh_q;
    logic                  unusedPolyTop;

    // The leading polynomial term is implicit in the shift-out of the MSB.
    assign unusedPolyTop = poly[CRC_WIDTH];

    // Clear only marks the state fresh, so the init value latched alongside it
    // is picked up on the first data beat rather than a cycle too early.
    always_comb begin
        dataOrdered = data_in;
        if (data_reverse) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                dataOrdered[i] = data_in[DATA_WIDTH-1-i];
            end
        end
        seed    = fresh_q ? init : state_q;
        state_d = seed;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (state_d[CRC_WIDTH-1] ^ dataOrdered[i]) begin
                state_d = (state_d << 1) ^ poly[CRC_WIDTH-1:0];
            end else begin
                state_d = state_d << 1;
            end
        end
        stateView = seed;
        if (crc_reverse) begin
            for (int i = 0; i < CRC_WIDTH; i++) begin
                stateView[i] = seed[CRC_WIDTH-1-i];
            end
        end
        crc_out = stateView ^ xorout;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= '0;
            fresh_q <= 1'b1;
        end else if (clear) begin
            fresh_q <= 1'b1;
        end else if (data_in_valid) begin
            state_q <= state_d;
            fresh_q <= 1'b0;
        end
    end
endmodule

module crc_tx_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int CRC_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CRC_WIDTH-1:0] init_in,
    input  logic [CRC_WIDTH:0]   poly_in,
    input  logic                 data_reverse,
    input  logic                 crc_reverse,
    input  logic [CRC_WIDTH-1:0] xorout_in,
    crc_tx_framer_if.master      bus,
    output logic [15:0]          frame_cnt
);
    if (CRC_WIDTH > DATA_WIDTH) begin : gWidthCheck
        $error("crc_tx_framer: CRC_WIDTH must not exceed DATA_WIDTH");
    end

    typedef enum logic [1:0] {INIT, PASS, CRC} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] mData_q;
    logic                  mValid_q;
    logic                  mLast_q;
    logic                  mCrc_q;
    logic [15:0]           frameCnt_q;
    logic [CRC_WIDTH-1:0]  init_q;
    logic [CRC_WIDTH:0]    poly_q;
    logic                  dataRev_q;
    logic                  crcRev_q;
    logic [CRC_WIDTH-1:0]  xorout_q;

    logic                  outFree;
    logic                  sReady;
    logic                  accept;
    logic [CRC_WIDTH-1:0]  crcOut;
    logic [DATA_WIDTH-1:0] crcBeat_d;

    assign outFree = !mValid_q || bus.m_ready;
    assign sReady  = (state_q == PASS) && outFree;
    assign accept  = bus.s_valid && sReady;

    always_comb begin
        crcBeat_d                = '0;
        crcBeat_d[CRC_WIDTH-1:0] = crcOut;
    end

    crc #(
        .DATA_WIDTH(DATA_WIDTH),
        .CRC_WIDTH (CRC_WIDTH)
    ) u_crc (
        .clk          (clk),
        .resetn       (~reset),
        .clear        (state_q == INIT),
        .data_in_valid(accept),
        .data_in      (bus.s_data),
        .init         (init_q),
        .poly         (poly_q),
        .data_reverse (dataRev_q),
        .crc_reverse  (crcRev_q),
        .xorout       (xorout_q),
        .crc_out      (crcOut)
    );

    // A downstream handshake frees the register; a load in the same cycle
    // overrides that and keeps m_valid high with the new beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            mData_q    <= '0;
            mValid_q   <= 1'b0;
            mLast_q    <= 1'b0;
            mCrc_q     <= 1'b0;
            frameCnt_q <= '0;
            init_q     <= '0;
            poly_q     <= '0;
            dataRev_q  <= 1'b0;
            crcRev_q   <= 1'b0;
            xorout_q   <= '0;
        end else begin
            if (mValid_q && bus.m_ready && mCrc_q) begin
                frameCnt_q <= frameCnt_q + 16'd1;
            end
            if (bus.m_ready) begin
                mValid_q <= 1'b0;
            end
            case (state_q)
                INIT: begin
                    init_q    <= init_in;
                    poly_q    <= poly_in;
                    dataRev_q <= data_reverse;
                    crcRev_q  <= crc_reverse;
                    xorout_q  <= xorout_in;
                    state_q   <= PASS;
                end
                PASS: begin
                    if (accept) begin
                        mData_q  <= bus.s_data;
                        mValid_q <= 1'b1;
                        mLast_q  <= 1'b0;
                        mCrc_q   <= 1'b0;
                        if (bus.s_last) begin
                            state_q <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (outFree) begin
                        mData_q  <= crcBeat_d;
                        mValid_q <= 1'b1;
                        mLast_q  <= 1'b1;
                        mCrc_q   <= 1'b1;
                        state_q  <= INIT;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign bus.s_ready = sReady;
    assign bus.m_data  = mData_q;
    assign bus.m_valid = mValid_q;
    assign bus.m_last  = mLast_q;
    assign bus.m_crc   = mCrc_q;
    assign frame_cnt   = frameCnt_q;
endmodule

// File: tb/tb_crc_tx_framer.sv
// Directed bench for crc_tx_framer using the "123456789" check string with
// CRC-8/SMBUS (0xF4) and CRC-8/MAXIM (0xA1).
module tb_crc_tx_framer;
    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic [7:0]  initIn   = 8'h00;
    logic [8:0]  polyIn   = 9'h107;
    logic        dataRev  = 1'b0;
    logic        crcRev   = 1'b0;
    logic [7:0]  xoroutIn = 8'h00;
    logic [15:0] frameCnt;

    int errors      = 0;
    int checks      = 0;
    int stallErrors = 0;
    int gapCount    = 0;

    logic [9:0] rxBeats[$];
    logic       prevStall = 1'b0;
    logic [9:0] prevBeat  = '0;

    crc_tx_framer_if #(.DATA_WIDTH(8)) busIf ();

    crc_tx_framer #(
        .DATA_WIDTH(8),
        .CRC_WIDTH (8)
    ) dut (
        .clk         (clock),
        .reset       (reset),
        .init_in     (initIn),
        .poly_in     (polyIn),
        .data_reverse(dataRev),
        .crc_reverse (crcRev),
        .xorout_in   (xoroutIn),
        .bus         (busIf),
        .frame_cnt   (frameCnt)
    );

    always #5 clock = ~clock;

    // Records every downstream handshake as {m_last, m_crc, m_data} and flags
    // any change of the held beat while the output is stalled.
    always @(negedge clock) begin
        if (reset) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall && ({busIf.m_last, busIf.m_crc, busIf.m_data} !== prevBeat)) begin
                stallErrors++;
            end
            if (busIf.m_valid && busIf.m_ready) begin
                rxBeats.push_back({busIf.m_last, busIf.m_crc, busIf.m_data});
            end
            prevStall = busIf.m_valid && !busIf.m_ready;
            prevBeat  = {busIf.m_last, busIf.m_crc, busIf.m_data};
        end
    end

    function automatic logic [9:0] expBeat(input int idx, input logic [7:0] crcFirst,
                                           input logic [7:0] crcLater);
        int pos;
        pos = idx % 10;
        if (pos == 9) begin
            return {2'b11, (idx < 10) ? crcFirst : crcLater};
        end
        return {2'b00, 8'(8'h31 + pos)};
    endfunction

    task automatic setCfg(input logic [8:0] poly, input logic dRev, input logic cRev);
        initIn   = 8'h00;
        polyIn   = poly;
        dataRev  = dRev;
        crcRev   = cRev;
        xoroutIn = 8'h00;
    endtask

    task automatic doReset();
        @(posedge clock);
        #1 reset = 1'b1;
        busIf.s_valid = 1'b0;
        busIf.m_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        rxBeats.delete();
        stallErrors = 0;
    endtask

    task automatic settle();
        busIf.s_valid = 1'b0;
        busIf.m_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    // Streams nFrames copies of "123456789"; optionally swaps to MAXIM cfg after
    // changeAt accepted beats, or stops driving after stopAt accepted beats.
    task automatic sendFrames(input int nFrames, input int changeAt, input int stopAt,
                              input bit randReady);
        int  total   = nFrames * 9;
        int  sent    = 0;
        int  budget  = 0;
        bit  gapOpen = 1'b0;
        bit  gapDone = 1'b0;
        bit  accept;
        gapCount = 0;
        while ((sent < total || rxBeats.size() < nFrames * 10 || (gapOpen && !gapDone))
               && budget < 3000) begin
            busIf.m_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < total) begin
                busIf.s_valid = 1'b1;
                busIf.s_data  = 8'(8'h31 + sent % 9);
                busIf.s_last  = (sent % 9 == 8);
            end else begin
                busIf.s_valid = 1'b0;
                busIf.s_last  = 1'b0;
            end
            @(negedge clock);
            if (gapOpen && !gapDone) begin
                if (busIf.s_ready) gapDone = 1'b1;
                else gapCount++;
            end
            accept = busIf.s_valid && busIf.s_ready;
            @(posedge clock);
            #1;
            budget++;
            if (accept) begin
                sent++;
                if (sent == 9) gapOpen = 1'b1;
                if (sent == changeAt) setCfg(9'h131, 1'b1, 1'b1);
                if (sent == stopAt) begin
                    busIf.s_valid = 1'b0;
                    return;
                end
            end
        end
        busIf.s_valid = 1'b0;
        busIf.m_ready = 1'b1;
        if (budget >= 3000) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: sent %0d beats, received %0d", sent, rxBeats.size());
        end
    endtask

    task automatic test_reset();
        busIf.s_valid = 1'b0;
        busIf.s_last  = 1'b0;
        busIf.s_data  = 8'h00;
        busIf.m_ready = 1'b1;
        setCfg(9'h107, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if ({busIf.s_ready, busIf.m_valid, busIf.m_last, busIf.m_crc} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 0000",
                     {busIf.s_ready, busIf.m_valid, busIf.m_last, busIf.m_crc});
        end
        checks++;
        if (busIf.m_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h want 00", busIf.m_data);
        end
        checks++;
        if (frameCnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_frame_cnt: got %0d want 0", frameCnt);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (busIf.s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL init_s_ready: got %b want 0", busIf.s_ready);
        end
        @(negedge clock);
        checks++;
        if (busIf.s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pass_s_ready: got %b want 1", busIf.s_ready);
        end
    endtask

    task automatic test_smbus();
        setCfg(9'h107, 1'b0, 1'b0);
        doReset();
        sendFrames(1, -1, -1, 1'b0);
        settle();
        checks++;
        if (rxBeats.size() !== 10) begin
            errors++;
            $display("[TB] FAIL smbus_count: got %0d want 10", rxBeats.size());
        end
        for (int i = 0; i < rxBeats.size() && i < 10; i++) begin
            checks++;
            if (rxBeats[i] !== expBeat(i, 8'hF4, 8'hF4)) begin
                errors++;
                $display("[TB] FAIL smbus_beat%0d: got %h want %h", i, rxBeats[i],
                         expBeat(i, 8'hF4, 8'hF4));
            end
        end
        checks++;
        if (gapCount !== 2) begin
            errors++;
            $display("[TB] FAIL smbus_gap: got %0d want 2", gapCount);
        end
        checks++;
        if (frameCnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL smbus_frame_cnt: got %0d want 1", frameCnt);
        end
    endtask

    task automatic test_maxim();
        setCfg(9'h131, 1'b1, 1'b1);
        doReset();
        sendFrames(1, -1, -1, 1'b0);
        settle();
        checks++;
        if (rxBeats.size() !== 10) begin
            errors++;
            $display("[TB] FAIL maxim_count: got %0d want 10", rxBeats.size());
        end
        for (int i = 0; i < rxBeats.size() && i < 10; i++) begin
            checks++;
            if (rxBeats[i] !== expBeat(i, 8'hA1, 8'hA1)) begin
                errors++;
                $display("[TB] FAIL maxim_beat%0d: got %h want %h", i, rxBeats[i],
                         expBeat(i, 8'hA1, 8'hA1));
            end
        end
    endtask

    task automatic test_back_to_back();
        setCfg(9'h107, 1'b0, 1'b0);
        doReset();
        sendFrames(2, -1, -1, 1'b0);
        settle();
        checks++;
        if (rxBeats.size() !== 20) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d want 20", rxBeats.size());
        end
        for (int i = 0; i < rxBeats.size() && i < 20; i++) begin
            checks++;
            if (rxBeats[i] !== expBeat(i, 8'hF4, 8'hF4)) begin
                errors++;
                $display("[TB] FAIL b2b_beat%0d: got %h want %h", i, rxBeats[i],
                         expBeat(i, 8'hF4, 8'hF4));
            end
        end
        checks++;
        if (frameCnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL b2b_frame_cnt: got %0d want 2", frameCnt);
        end
    endtask

    task automatic test_random_ready();
        setCfg(9'h107, 1'b0, 1'b0);
        doReset();
        sendFrames(1, -1, -1, 1'b1);
        settle();
        checks++;
        if (rxBeats.size() !== 10) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d want 10", rxBeats.size());
        end
        for (int i = 0; i < rxBeats.size() && i < 10; i++) begin
            checks++;
            if (rxBeats[i] !== expBeat(i, 8'hF4, 8'hF4)) begin
                errors++;
                $display("[TB] FAIL stall_beat%0d: got %h want %h", i, rxBeats[i],
                         expBeat(i, 8'hF4, 8'hF4));
            end
        end
        checks++;
        if (stallErrors !== 0) begin
            errors++;
            $display("[TB] FAIL stall_hold: got %0d changes during stall want 0", stallErrors);
        end
        checks++;
        if (frameCnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL stall_frame_cnt: got %0d want 1", frameCnt);
        end
    endtask

    task automatic test_cfg_change();
        setCfg(9'h107, 1'b0, 1'b0);
        doReset();
        sendFrames(2, 4, -1, 1'b0);
        settle();
        checks++;
        if (rxBeats.size() !== 20) begin
            errors++;
            $display("[TB] FAIL cfg_count: got %0d want 20", rxBeats.size());
        end
        for (int i = 0; i < rxBeats.size() && i < 20; i++) begin
            checks++;
            if (rxBeats[i] !== expBeat(i, 8'hF4, 8'hA1)) begin
                errors++;
                $display("[TB] FAIL cfg_beat%0d: got %h want %h", i, rxBeats[i],
                         expBeat(i, 8'hF4, 8'hA1));
            end
        end
    endtask

    task automatic test_reset_midframe();
        int crcBeats = 0;
        setCfg(9'h107, 1'b0, 1'b0);
        doReset();
        sendFrames(2, -1, 13, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busIf.s_ready, busIf.m_valid, busIf.m_last, busIf.m_crc} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midreset_flags: got %b want 0000",
                     {busIf.s_ready, busIf.m_valid, busIf.m_last, busIf.m_crc});
        end
        checks++;
        if (busIf.m_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_data: got %h want 00", busIf.m_data);
        end
        checks++;
        if (frameCnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_frame_cnt: got %0d want 0", frameCnt);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        foreach (rxBeats[i]) if (rxBeats[i][8]) crcBeats++;
        checks++;
        if (rxBeats.size() !== 13 || crcBeats !== 1) begin
            errors++;
            $display("[TB] FAIL midreset_partial: got %0d beats %0d crc want 13 beats 1 crc",
                     rxBeats.size(), crcBeats);
        end
        rxBeats.delete();
        sendFrames(1, -1, -1, 1'b0);
        settle();
        checks++;
        if (rxBeats.size() !== 10) begin
            errors++;
            $display("[TB] FAIL replay_count: got %0d want 10", rxBeats.size());
        end
        for (int i = 0; i < rxBeats.size() && i < 10; i++) begin
            checks++;
            if (rxBeats[i] !== expBeat(i, 8'hF4, 8'hF4)) begin
                errors++;
                $display("[TB] FAIL replay_beat%0d: got %h want %h", i, rxBeats[i],
                         expBeat(i, 8'hF4, 8'hF4));
            end
        end
        checks++;
        if (frameCnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL replay_frame_cnt: got %0d want 1", frameCnt);
        end
    endtask

    initial begin
        test_reset();
        test_smbus();
        test_maxim();
        test_back_to_back();
        test_random_ready();
        test_cfg_change();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/crc_tx_framer.md
# crc_tx_framer

Stream framer that sits directly upstream of the `crc` core and drives it. It passes a valid/ready payload stream through a one-deep output register and feeds every accepted beat into an internal `crc` instance. After the last payload beat, it appends the finished CRC as one extra beat. It also owns core initialisation, latches the CRC configuration once per frame, and counts completed frames.

## Interface
- `DATA_WIDTH`, default 8: payload beat width.
- `CRC_WIDTH`, default 8: CRC width. Must be ≤ `DATA_WIDTH`; elaboration fails otherwise.
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: asynchronous, active-high reset. Drives the core's `resetn` as `~reset`.
- `init_in` input, `CRC_WIDTH` bits: initial CRC state. Latched in INIT.
- `poly_in` input, `CRC_WIDTH+1` bits: polynomial in full notation. Latched in INIT.
- `data_reverse`, `crc_reverse` inputs, 1 bit each: bit-reverse controls. Latched in INIT.
- `xorout_in` input, `CRC_WIDTH` bits: output XOR mask. Latched in INIT.
- `s_data` input, `DATA_WIDTH` bits: payload data.
- `s_valid` input, 1 bit: payload valid.
- `s_last` input, 1 bit: marks the last payload beat of a frame.
- `s_ready` output, 1 bit: framer accepts a beat.
- `m_data` output, `DATA_WIDTH` bits: output beat.
- `m_valid` output, 1 bit: output beat valid.
- `m_last` output, 1 bit: set only on the CRC beat.
- `m_crc` output, 1 bit: set only on the CRC beat.
- `m_ready` input, 1 bit: downstream accepts the output beat.
- `frame_cnt` output, 16 bits: count of CRC beats handed downstream. Wraps.

## Operation
- FSM states: INIT, PASS, CRC.
- INIT (exactly one cycle):
  - drive core `clear`=1;
  - register all cfg inputs into shadow registers, which drive the core until the next INIT;
  - `s_ready`=0;
  - next state is PASS.
- PASS:
  - `s_ready` = `!m_valid || m_ready`;
  - a beat is accepted when `s_valid && s_ready`;
  - on acceptance: core `data_in_valid`=1 with `data_in`=`s_data`; output register loads `s_data`, `m_last`=0, `m_crc`=0;
  - if the accepted beat has `s_last`=1, next state is CRC.
- CRC:
  - `s_ready`=0;
  - when `!m_valid || m_ready`: output register loads {zeros, core `crc_out`} (CRC in bits `[CRC_WIDTH-1:0]`, upper bits 0), `m_last`=1, `m_crc`=1; then go to INIT.
- Output register:
  - `m_valid` clears when `m_ready` is high and nothing new is loaded;
  - data, `m_last` and `m_crc` hold while `m_valid && !m_ready`.
- `frame_cnt` increments when the CRC beat handshakes downstream (`m_valid && m_ready && m_crc`). It wraps 0xFFFF→0.
- Single-beat frames (first beat has `s_last`=1) are legal. Zero-length frames do not exist.
- Cfg inputs may change at any time; changes take effect only at the next INIT.
- `s_valid` with `s_ready`=0 has no effect. Upstream must hold the beat stable until it is accepted.

## Timing
- Reset values:
  - `s_ready`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `m_crc`=0, `frame_cnt`=0;
  - shadow cfg registers = 0;
  - state = INIT.
- First cycle after reset deasserts: INIT. `s_ready` can first be 1 in the following cycle.
- Payload latency: a beat accepted at edge N is on `m_*` after edge N.
- CRC latency: the core's `crc_out` is valid after the edge that accepted the last beat. With `m_ready`=1, the CRC beat appears on the cycle immediately after the last payload beat, with no bubble.
- Inter-frame gap: `s_ready`=0 for exactly 2 cycles (CRC + INIT) when `m_ready`=1. CRC is extended by downstream stall cycles.
- Throughput: one beat per cycle sustained while `m_ready`=1.
- Reset mid-frame:
  - the partial frame is discarded and no CRC beat is produced;
  - an in-flight `m_*` beat is dropped;
  - `frame_cnt` returns to 0.
- Simultaneous `m_ready` handshake and new load in the same cycle: the new beat replaces the old one, and `m_valid` stays 1.

## Test plan
- CRC-8/SMBUS (poly 0x107, init 0x00, no reverse, xorout 0x00), bytes "123456789" (0x31..0x39), `m_ready`=1 → nine payload beats unchanged, then beat 0x00F4 (low byte 0xF4) with `m_last`=1 and `m_crc`=1; `frame_cnt`=1; `s_ready` low for 2 cycles.
- CRC-8/MAXIM (poly 0x131, init 0x00, `data_reverse`=1, `crc_reverse`=1, xorout 0x00), same bytes → CRC beat 0xA1.
- Two back-to-back SMBUS "123456789" frames with `s_valid` always high → both CRC beats are 0xF4 (proves re-clear between frames); `frame_cnt`=2.
- Same frame with `m_ready` random ~50% → output sequence identical to the first scenario; no duplicated or lost beats; `m_data` stable during every stall.
- Change `poly_in` to 0x131 mid-frame, during the SMBUS frame → that frame's CRC is still 0xF4; the next frame uses the new polynomial.
- Assert `reset` after beat 4, then replay the full frame → no CRC beat for the partial frame; all outputs equal their reset values; the replayed frame gives 0xF4 and `frame_cnt`=1.
